// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ID/EX ALU-control stage: opcodes, ALUOp classes,
// funct7 values, ALU operation codes and the decode result record.
package alu_ctrl_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ALU    = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b00001;
  localparam logic [4:0] ALU_MUL    = 5'b00010;
  localparam logic [4:0] ALU_MULH   = 5'b00011;
  localparam logic [4:0] ALU_MULHSU = 5'b00100;
  localparam logic [4:0] ALU_MULHU  = 5'b00101;
  localparam logic [4:0] ALU_DIV    = 5'b00110;
  localparam logic [4:0] ALU_DIVU   = 5'b00111;
  localparam logic [4:0] ALU_REM    = 5'b01000;
  localparam logic [4:0] ALU_REMU   = 5'b01001;
  localparam logic [4:0] ALU_XOR    = 5'b01010;
  localparam logic [4:0] ALU_OR     = 5'b01011;
  localparam logic [4:0] ALU_AND    = 5'b01100;
  localparam logic [4:0] ALU_SLL    = 5'b01101;
  localparam logic [4:0] ALU_SRL    = 5'b01110;
  localparam logic [4:0] ALU_SRA    = 5'b01111;
  localparam logic [4:0] ALU_SLT    = 5'b10000;
  localparam logic [4:0] ALU_SLTU   = 5'b10001;
  localparam logic [4:0] ALU_EQ     = 5'b10010;
  localparam logic [4:0] ALU_NE     = 5'b10011;

  typedef struct packed {
    logic [4:0] ctrl;
    logic       alu_src;
    logic       illegal;
    logic       multicycle;
  } decode_t;

  // funct3 map shared by R-type (funct7=0) and I-type arithmetic.
  function automatic logic [4:0] base_op(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [4:0] muldiv_op(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'b000:  op = ALU_MUL;
      3'b001:  op = ALU_MULH;
      3'b010:  op = ALU_MULHSU;
      3'b011:  op = ALU_MULHU;
      3'b100:  op = ALU_DIV;
      3'b101:  op = ALU_DIVU;
      3'b110:  op = ALU_REM;
      default: op = ALU_REMU;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_busy_counter.sv
// Counts down the remaining EX cycles of a divide so the decode stage can
// hold off upstream; latencies of 0 or 1 load zero and never report busy.
module alu_busy_counter #(
  parameter int DIV_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy
);

  localparam int CW = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [CW-1:0] LOAD_VAL = (DIV_LATENCY > 0) ? CW'(DIV_LATENCY - 1) : '0;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign busy = (r_cnt != '0);

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered ALU-control decode between ID and EX with valid/ready handshake,
// RV32M decode and a divider-busy stall on the input side.
module alu_ctrl_stage
  import alu_ctrl_pkg::*;
#(
  parameter int INSTR_WIDTH   = 32,
  parameter int ALUCTRL_WIDTH = 5,
  parameter int M_EXT         = 1,
  parameter int DIV_LATENCY   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_aluop,
  input  logic [INSTR_WIDTH-1:0]   in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ALUCTRL_WIDTH-1:0] out_alu_ctrl,
  output logic                     out_alu_src,
  output logic                     out_multicycle,
  output logic                     out_illegal
);

  function automatic decode_t decode(input logic [1:0] aluop, input logic [6:0] opc,
                                     input logic [2:0] f3, input logic [6:0] f7);
    decode_t d;
    d = '{ctrl: ALU_ADD, alu_src: 1'b0, illegal: 1'b0, multicycle: 1'b0};
    case (aluop)
      ALUOP_ADD: d.alu_src = 1'b1;
      ALUOP_BRANCH: begin
        case (f3)
          3'b000:        d.ctrl = ALU_EQ;
          3'b001:        d.ctrl = ALU_NE;
          3'b100, 3'b101: d.ctrl = ALU_SLT;
          3'b110, 3'b111: d.ctrl = ALU_SLTU;
          default:       d.illegal = 1'b1;
        endcase
      end
      ALUOP_ALU: begin
        if (opc == OP_R) begin
          case (f7)
            F7_BASE: d.ctrl = base_op(f3);
            F7_ALT: begin
              if (f3 == 3'b000)      d.ctrl = ALU_SUB;
              else if (f3 == 3'b101) d.ctrl = ALU_SRA;
              else                   d.illegal = 1'b1;
            end
            F7_MULDIV: begin
              if (M_EXT != 0) d.ctrl = muldiv_op(f3);
              else            d.illegal = 1'b1;
            end
            default: d.illegal = 1'b1;
          endcase
        end else if (opc == OP_I) begin
          d.alu_src = 1'b1;
          case (f3)
            3'b001: begin
              if (f7 == F7_BASE) d.ctrl = ALU_SLL;
              else               d.illegal = 1'b1;
            end
            3'b101: begin
              if (f7 == F7_BASE)     d.ctrl = ALU_SRL;
              else if (f7 == F7_ALT) d.ctrl = ALU_SRA;
              else                   d.illegal = 1'b1;
            end
            default: d.ctrl = base_op(f3);
          endcase
        end else begin
          d.illegal = 1'b1;
        end
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) d.ctrl = ALU_ADD;
    d.multicycle = (d.ctrl == ALU_DIV) || (d.ctrl == ALU_DIVU) ||
                   (d.ctrl == ALU_REM) || (d.ctrl == ALU_REMU);
    return d;
  endfunction

  decode_t w_dec;
  logic    w_xfer;
  logic    w_busy;
  logic    w_load;
  logic    w_unused;

  logic                     r_valid;
  logic [ALUCTRL_WIDTH-1:0] r_alu_ctrl;
  logic                     r_alu_src;
  logic                     r_multicycle;
  logic                     r_illegal;

  assign w_dec    = decode(in_aluop, in_instr[6:0], in_instr[14:12], in_instr[31:25]);
  assign w_unused = ^{in_instr[24:15], in_instr[11:7]};

  assign in_ready = !w_busy && (!r_valid || out_ready);
  assign w_xfer   = in_valid && in_ready;
  assign w_load   = r_valid && out_ready && r_multicycle;

  alu_busy_counter #(.DIV_LATENCY(DIV_LATENCY)) u_busy (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .busy  (w_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_alu_ctrl   <= '0;
      r_alu_src    <= 1'b0;
      r_multicycle <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (w_xfer) begin
      r_valid      <= 1'b1;
      r_alu_ctrl   <= ALUCTRL_WIDTH'(w_dec.ctrl);
      r_alu_src    <= w_dec.alu_src;
      r_multicycle <= w_dec.multicycle;
      r_illegal    <= w_dec.illegal;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid      = r_valid;
  assign out_alu_ctrl   = r_alu_ctrl;
  assign out_alu_src    = r_alu_src;
  assign out_multicycle = r_multicycle;
  assign out_illegal    = r_illegal;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Self-checking bench: table vectors through a scoreboard, plus reset,
// divider-stall, backpressure and M_EXT=0 sequences.
module tb_alu_ctrl_stage;

  localparam logic [4:0] C_ADD = 5'd0,  C_SUB = 5'd1,  C_MUL = 5'd2,  C_DIV = 5'd6;
  localparam logic [4:0] C_REMU = 5'd9, C_XOR = 5'd10, C_OR = 5'd11,  C_AND = 5'd12;
  localparam logic [4:0] C_SLL = 5'd13, C_SRA = 5'd15, C_SLT = 5'd16, C_SLTU = 5'd17;
  localparam logic [4:0] C_EQ = 5'd18,  C_NE = 5'd19;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_aluop;
  logic [31:0] in_instr;
  logic [4:0]  out_alu_ctrl;
  logic        out_alu_src, out_multicycle, out_illegal;

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [1:0]  in_aluop2;
  logic [31:0] in_instr2;
  logic [4:0]  out_alu_ctrl2;
  logic        out_alu_src2, out_multicycle2, out_illegal2;

  always #5 clk = ~clk;

  alu_ctrl_stage #(.INSTR_WIDTH(32), .ALUCTRL_WIDTH(5), .M_EXT(1), .DIV_LATENCY(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_ctrl(out_alu_ctrl), .out_alu_src(out_alu_src),
    .out_multicycle(out_multicycle), .out_illegal(out_illegal)
  );

  alu_ctrl_stage #(.INSTR_WIDTH(32), .ALUCTRL_WIDTH(5), .M_EXT(0), .DIV_LATENCY(0)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_aluop(in_aluop2), .in_instr(in_instr2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_alu_ctrl(out_alu_ctrl2), .out_alu_src(out_alu_src2),
    .out_multicycle(out_multicycle2), .out_illegal(out_illegal2)
  );

  typedef struct {
    string       name;
    logic [1:0]  aluop;
    logic [31:0] instr;
    logic [7:0]  exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // {ctrl, alu_src, multicycle, illegal}
  function automatic logic [7:0] E(input logic [4:0] c, input logic s, input logic m, input logic i);
    return {c, s, m, i};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [1:0] a, input logic [31:0] ins, input logic [7:0] e);
    vec_t v;
    v.name = name; v.aluop = a; v.instr = ins; v.exp = e;
    vecs.push_back(v);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got %0h expected none",
                 {out_alu_ctrl, out_alu_src, out_multicycle, out_illegal});
      end else begin
        sb_t s;
        s = exp_q.pop_front();
        check(s.name, {24'd0, out_alu_ctrl, out_alu_src, out_multicycle, out_illegal}, {24'd0, s.exp});
      end
    end
  end

  // Drive one op until accepted; called and returns at posedge+#1.
  task automatic send(input string name, input logic [1:0] a, input logic [31:0] ins, input logic [7:0] e);
    bit  acc;
    sb_t s;
    acc = 0;
    in_aluop = a; in_instr = ins; in_valid = 1'b1;
    for (int k = 0; k < 40 && !acc; k++) begin
      @(negedge clk);
      if (in_ready) acc = 1;
    end
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout %s: got in_ready=0 expected 1", name);
    end else begin
      s.name = name; s.exp = e;
      exp_q.push_back(s);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid && in_ready) done = 1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic send2(input string name, input logic [1:0] a, input logic [31:0] ins, input logic [7:0] e);
    in_aluop2 = a; in_instr2 = ins; in_valid2 = 1'b1;
    @(negedge clk);
    check({name, "_ready"}, {31'd0, in_ready2}, 32'd1);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    @(negedge clk);
    check({name, "_valid"}, {31'd0, out_valid2}, 32'd1);
    check(name, {24'd0, out_alu_ctrl2, out_alu_src2, out_multicycle2, out_illegal2}, {24'd0, e});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    add("sub",        2'b10, 32'h40B50533, E(C_SUB,  0, 0, 0));
    add("srai",       2'b10, 32'h40055513, E(C_SRA,  1, 0, 0));
    add("addi_b30",   2'b10, 32'h40050513, E(C_ADD,  1, 0, 0));
    add("xor",        2'b10, 32'h00B54533, E(C_XOR,  0, 0, 0));
    add("sltu",       2'b10, 32'h00B53533, E(C_SLTU, 0, 0, 0));
    add("sra",        2'b10, 32'h40B55533, E(C_SRA,  0, 0, 0));
    add("mul",        2'b10, 32'h02B50533, E(C_MUL,  0, 0, 0));
    add("div",        2'b10, 32'h02B54533, E(C_DIV,  0, 1, 0));
    add("remu",       2'b10, 32'h02B57533, E(C_REMU, 0, 1, 0));
    add("r_alt_f3_1", 2'b10, 32'h40B51533, E(C_ADD,  0, 0, 1));
    add("r_f7_bad",   2'b10, 32'h04B50533, E(C_ADD,  0, 0, 1));
    add("slli",       2'b10, 32'h00151513, E(C_SLL,  1, 0, 0));
    add("slli_alt",   2'b10, 32'h40151513, E(C_ADD,  1, 0, 1));
    add("srli_bad",   2'b10, 32'h02155513, E(C_ADD,  1, 0, 1));
    add("ori_b30",    2'b10, 32'h40056513, E(C_OR,   1, 0, 0));
    add("andi_neg",   2'b10, 32'hFFF57513, E(C_AND,  1, 0, 0));
    add("alu_load_op",2'b10, 32'h00052503, E(C_ADD,  0, 0, 1));
    add("aluop00",    2'b00, 32'h02B54533, E(C_ADD,  1, 0, 0));
    add("beq",        2'b01, 32'h00B50063, E(C_EQ,   0, 0, 0));
    add("bne",        2'b01, 32'h00B51063, E(C_NE,   0, 0, 0));
    add("bge",        2'b01, 32'h00B55063, E(C_SLT,  0, 0, 0));
    add("bltu",       2'b01, 32'h00B56063, E(C_SLTU, 0, 0, 0));
    add("br_f3_010",  2'b01, 32'h00B52063, E(C_ADD,  0, 0, 1));
    add("aluop11",    2'b11, 32'h00B50533, E(C_ADD,  0, 0, 1));

    reset = 1'b1; in_valid = 1'b1; in_aluop = 2'b10; in_instr = 32'h40B50533; out_ready = 1'b1;
    in_valid2 = 1'b1; in_aluop2 = 2'b10; in_instr2 = 32'h40B50533; out_ready2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_outputs", {24'd0, out_alu_ctrl, out_alu_src, out_multicycle, out_illegal}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid2", {31'd0, out_valid2}, 32'd0);
    @(posedge clk); #1;

    foreach (vecs[i]) send(vecs[i].name, vecs[i].aluop, vecs[i].instr, vecs[i].exp);
    wait_drain();
    repeat (4) @(posedge clk);
    #1;

    // Divide: in_ready low for exactly 3 cycles after the output handshake.
    send("div_seq", 2'b10, 32'h02B54533, E(C_DIV, 0, 1, 0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("busy_ready_%0d", k), {31'd0, in_ready}, (k == 0 || k == 4) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    wait_drain();

    // Backpressure: hold A for 5 cycles with B waiting, then drain and accept together.
    out_ready = 1'b0;
    send("stall_a", 2'b10, 32'h00B54533, E(C_XOR, 0, 0, 0));
    in_aluop = 2'b10; in_instr = 32'h40B50533; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall_valid_%0d", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("stall_ready_%0d", k), {31'd0, in_ready}, 32'd0);
      check($sformatf("stall_hold_%0d", k),
            {24'd0, out_alu_ctrl, out_alu_src, out_multicycle, out_illegal},
            {24'd0, E(C_XOR, 0, 0, 0)});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send("stall_b", 2'b10, 32'h40B50533, E(C_SUB, 0, 0, 0));
    @(negedge clk);
    check("drain_accept_valid", {31'd0, out_valid}, 32'd1);
    check("drain_accept_ctrl", {27'd0, out_alu_ctrl}, {27'd0, C_SUB});
    @(posedge clk); #1;
    wait_drain();

    send2("m0_mul",     2'b10, 32'h02B50533, E(C_ADD, 0, 0, 1));
    send2("m0_div",     2'b10, 32'h02B54533, E(C_ADD, 0, 0, 1));
    send2("m0_add",     2'b10, 32'h00B50533, E(C_ADD, 0, 0, 0));
    send2("m0_sub",     2'b10, 32'h40B50533, E(C_SUB, 0, 0, 0));
    send2("m0_br_010",  2'b01, 32'h00B52063, E(C_ADD, 0, 0, 1));
    send2("m0_aluop11", 2'b11, 32'h00B50533, E(C_ADD, 0, 0, 1));

    check("sb_leftover", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
